// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_pkg: shared types and limits for the pipeline hazard controller.
// Optional macro CUSTOM_DEFINE: register address width is taken from
// the REGFILE_ADDR_WIDTH macro instead of the RV32I default of 5.
package pipe_hazard_pkg;

`ifdef CUSTOM_DEFINE
`ifndef REGFILE_ADDR_WIDTH
`define REGFILE_ADDR_WIDTH 5
`endif
    localparam int REGFILE_ADDR_WIDTH = `REGFILE_ADDR_WIDTH;
`else
    localparam int REGFILE_ADDR_WIDTH = 5;
`endif

    localparam int LOAD_LATENCY_MAX = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic memwb_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline stages and the
// per-stage hold/bubble controls returned to them.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_pkg::*;

    logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr;
    logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr;
    logic                          ID_Rs1_used;
    logic                          ID_Rs2_used;
    logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr;
    logic                          EX_MemRead;
    logic                          EX_Branch_taken;
    logic                          MEM_Req;
    logic                          MEM_Ack;

    logic                          PC_Stall;
    logic                          IFID_Stall;
    logic                          IFID_Flush;
    logic                          IDEX_Stall;
    logic                          IDEX_Flush;
    logic                          EXMEM_Stall;
    logic                          MEMWB_Flush;
    logic                          Mem_timeout_err;
    logic [31:0]                   Stall_cycles;
    logic [31:0]                   Flush_events;

    modport master (
        output ID_Rs1_addr, ID_Rs2_addr, ID_Rs1_used, ID_Rs2_used,
               EX_Rd_addr, EX_MemRead, EX_Branch_taken, MEM_Req, MEM_Ack,
        input  PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush,
               EXMEM_Stall, MEMWB_Flush, Mem_timeout_err,
               Stall_cycles, Flush_events
    );

    modport slave (
        input  ID_Rs1_addr, ID_Rs2_addr, ID_Rs1_used, ID_Rs2_used,
               EX_Rd_addr, EX_MemRead, EX_Branch_taken, MEM_Req, MEM_Ack,
        output PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush,
               EXMEM_Stall, MEMWB_Flush, Mem_timeout_err,
               Stall_cycles, Flush_events
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// hazard_match: one source-operand vs. EX destination compare.
// x0 is never a real dependency and an unread operand never matches.
module hazard_match
    import pipe_hazard_pkg::*;
(
    input  logic [REGFILE_ADDR_WIDTH-1:0] rs_addr,
    input  logic                          rs_used,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr,
    output logic                          hit
);

    assign hit = rs_used && (rd_addr != '0) && (rs_addr == rd_addr);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush generator for the 5-stage pipeline.
// Priority each cycle: MEM wait > EX redirect > load-use.
// Optional macro HAZARD_PERF_CNT_EN: builds the Stall_cycles/Flush_events
// counters; otherwise both ports read 0 and no counter flops exist.
//
// state    | meaning
// RUN      | normal issue, load-use detection active
// LU_STALL | extra load-use bubbles pending, lu_cnt = bubbles left
// MEM_WAIT | data memory busy, saved_state/lu_cnt held until MEM_Ack
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    pipe_hazard_ctrl_if.slave hz
);

    // Out-of-range latencies are clamped so lu_cnt never overflows.
    localparam int LL      = (LOAD_LATENCY < 1) ? 1 :
                             ((LOAD_LATENCY > LOAD_LATENCY_MAX) ? LOAD_LATENCY_MAX : LOAD_LATENCY);
    localparam int LU_W    = $clog2(LOAD_LATENCY_MAX + 1);
    localparam logic [LU_W-1:0] LU_INIT = LU_W'(LL - 1);
    localparam int WAIT_W  = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state, nxt_state, saved_state, nxt_saved;
    logic [LU_W-1:0]   lu_cnt, nxt_lu;
    logic [WAIT_W-1:0] wait_cnt, nxt_wait;
    logic              err_q, nxt_err, err_out;
    logic              rs1_hit, rs2_hit, lu_hit, mem_wait;
    hz_ctrl_t          ctrl;

    hazard_match u_match_rs1 (
        .rs_addr (hz.ID_Rs1_addr),
        .rs_used (hz.ID_Rs1_used),
        .rd_addr (hz.EX_Rd_addr),
        .hit     (rs1_hit)
    );

    hazard_match u_match_rs2 (
        .rs_addr (hz.ID_Rs2_addr),
        .rs_used (hz.ID_Rs2_used),
        .rd_addr (hz.EX_Rd_addr),
        .hit     (rs2_hit)
    );

    assign lu_hit   = hz.EX_MemRead && (rs1_hit || rs2_hit);
    assign mem_wait = hz.MEM_Req && !hz.MEM_Ack;

    // State, counters and sticky timeout flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RUN;
            saved_state <= RUN;
            lu_cnt      <= '0;
            wait_cnt    <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= nxt_state;
            saved_state <= nxt_saved;
            lu_cnt      <= nxt_lu;
            wait_cnt    <= nxt_wait;
            err_q       <= nxt_err;
        end
    end

    // Next-state and stage-control decode.
    always_comb begin
        ctrl      = '0;
        nxt_state = state;
        nxt_saved = saved_state;
        nxt_lu    = lu_cnt;
        nxt_wait  = wait_cnt;
        nxt_err   = err_q;

        if (mem_wait) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_stall = 1'b1;
            ctrl.memwb_flush = 1'b1;
            nxt_state        = MEM_WAIT;
            if (state != MEM_WAIT) nxt_saved = state;
            // Count saturates at the terminal value; the flag is visible in
            // the very cycle the count reaches it.
            if (MEM_TIMEOUT != 0) begin
                if (wait_cnt != WAIT_TC) nxt_wait = wait_cnt + WAIT_W'(1);
                if (nxt_wait == WAIT_TC) nxt_err = 1'b1;
            end
        end else begin
            nxt_wait = '0;
            // The Ack cycle itself raises no stall; a frozen LU count resumes next cycle.
            if (state == MEM_WAIT) nxt_state = saved_state;
            if (hz.EX_Branch_taken) begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
                nxt_state       = RUN;
                nxt_lu          = '0;
            end else if (state == LU_STALL) begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_stall = 1'b1;
                ctrl.idex_flush = 1'b1;
                nxt_lu          = lu_cnt - LU_W'(1);
                if (lu_cnt == LU_W'(1)) nxt_state = RUN;
            end else if (state == RUN && lu_hit) begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_stall = 1'b1;
                ctrl.idex_flush = 1'b1;
                if (LL > 1) begin
                    nxt_state = LU_STALL;
                    nxt_lu    = LU_INIT;
                end
            end
        end

        err_out = nxt_err;
        if (Reset) begin
            ctrl    = '0;
            err_out = 1'b0;
        end
    end

    assign hz.PC_Stall        = ctrl.pc_stall;
    assign hz.IFID_Stall      = ctrl.ifid_stall;
    assign hz.IFID_Flush      = ctrl.ifid_flush;
    assign hz.IDEX_Stall      = ctrl.idex_stall;
    assign hz.IDEX_Flush      = ctrl.idex_flush;
    assign hz.EXMEM_Stall     = ctrl.exmem_stall;
    assign hz.MEMWB_Flush     = ctrl.memwb_flush;
    assign hz.Mem_timeout_err = err_out;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    // Free-running perf counters, wrap at 2^32.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl.pc_stall)   stall_cnt <= stall_cnt + 32'd1;
            if (ctrl.ifid_flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign hz.Stall_cycles = stall_cnt;
    assign hz.Flush_events = flush_cnt;
`else
    assign hz.Stall_cycles = '0;
    assign hz.Flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LATENCY 1 and 3, MEM_TIMEOUT 8)
// share one input stream; each cycle's hand-computed outputs are queued by
// the stimulus and checked by an independent negedge monitor.
// Expected vector bit order: {PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall,
// IDEX_Flush, EXMEM_Stall, MEMWB_Flush, Mem_timeout_err}.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_pkg::*;

    localparam int AW = REGFILE_ADDR_WIDTH;

    localparam logic [7:0] Z   = 8'b0000_0000;
    localparam logic [7:0] LU  = 8'b1100_1000;
    localparam logic [7:0] BR  = 8'b0010_1000;
    localparam logic [7:0] MW  = 8'b1101_0110;
    localparam logic [7:0] MWE = 8'b1101_0111;
    localparam logic [7:0] E   = 8'b0000_0001;
    localparam logic [7:0] LUE = 8'b1100_1001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
    logic u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    bit seen_rst = 1'b0;

    typedef struct {
        logic [7:0] e1;
        logic [7:0] e3;
        bit         r;
        int         c;
    } exp_t;
    exp_t sbq[$];
    exp_t ent;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] m_st1 = '0, m_fl1 = '0, m_st3 = '0, m_fl3 = '0;
`endif

    pipe_hazard_ctrl_if if1 ();
    pipe_hazard_ctrl_if if3 ();

    assign if1.ID_Rs1_addr = rs1;  assign if3.ID_Rs1_addr = rs1;
    assign if1.ID_Rs2_addr = rs2;  assign if3.ID_Rs2_addr = rs2;
    assign if1.ID_Rs1_used = u1;   assign if3.ID_Rs1_used = u1;
    assign if1.ID_Rs2_used = u2;   assign if3.ID_Rs2_used = u2;
    assign if1.EX_Rd_addr  = rd;   assign if3.EX_Rd_addr  = rd;
    assign if1.EX_MemRead  = mr;   assign if3.EX_MemRead  = mr;
    assign if1.EX_Branch_taken = br; assign if3.EX_Branch_taken = br;
    assign if1.MEM_Req     = req;  assign if3.MEM_Req     = req;
    assign if1.MEM_Ack     = ack;  assign if3.MEM_Ack     = ack;

    pipe_hazard_ctrl #(.LOAD_LATENCY(1), .MEM_TIMEOUT(8)) u_ll1 (
        .Clk   (clk),
        .Reset (rst),
        .hz    (if1)
    );

    pipe_hazard_ctrl #(.LOAD_LATENCY(3), .MEM_TIMEOUT(8)) u_ll3 (
        .Clk   (clk),
        .Reset (rst),
        .hz    (if3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected in that cycle.
    task automatic step(input bit r, input int a1, input bit v1, input int a2, input bit v2,
                        input int d, input bit ld, input bit b, input bit q, input bit k,
                        input logic [7:0] e1, input logic [7:0] e3);
        @(posedge clk);
        #1;
        rst = r;
        rs1 = AW'(a1); u1 = v1;
        rs2 = AW'(a2); u2 = v2;
        rd  = AW'(d);  mr = ld;
        br  = b; req = q; ack = k;
        sbq.push_back('{e1: e1, e3: e3, r: r, c: cyc});
        cyc++;
    endtask

    task automatic idle(input logic [7:0] e1, input logic [7:0] e3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e1, e3);
    endtask

    task automatic memw(input logic [7:0] e1, input logic [7:0] e3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, e1, e3);
    endtask

    task automatic memack(input logic [7:0] e1, input logic [7:0] e3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, e1, e3);
    endtask

    // Monitor: pops one expectation per cycle and compares away from the edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            ent = sbq.pop_front();
            chk("ll1 ctrl", ent.c, {24'd0, if1.PC_Stall, if1.IFID_Stall, if1.IFID_Flush, if1.IDEX_Stall,
                                    if1.IDEX_Flush, if1.EXMEM_Stall, if1.MEMWB_Flush, if1.Mem_timeout_err},
                {24'd0, ent.e1});
            chk("ll3 ctrl", ent.c, {24'd0, if3.PC_Stall, if3.IFID_Stall, if3.IFID_Flush, if3.IDEX_Stall,
                                    if3.IDEX_Flush, if3.EXMEM_Stall, if3.MEMWB_Flush, if3.Mem_timeout_err},
                {24'd0, ent.e3});
            if (seen_rst) begin
`ifdef HAZARD_PERF_CNT_EN
                chk("ll1 stall_cycles", ent.c, if1.Stall_cycles, m_st1);
                chk("ll1 flush_events", ent.c, if1.Flush_events, m_fl1);
                chk("ll3 stall_cycles", ent.c, if3.Stall_cycles, m_st3);
                chk("ll3 flush_events", ent.c, if3.Flush_events, m_fl3);
`else
                chk("ll1 stall_cycles", ent.c, if1.Stall_cycles, 32'd0);
                chk("ll3 flush_events", ent.c, if3.Flush_events, 32'd0);
`endif
            end
            if (ent.r) seen_rst = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
            if (ent.r) begin
                m_st1 = '0; m_fl1 = '0; m_st3 = '0; m_fl3 = '0;
            end else begin
                m_st1 = m_st1 + 32'(ent.e1[7]);
                m_fl1 = m_fl1 + 32'(ent.e1[5]);
                m_st3 = m_st3 + 32'(ent.e3[7]);
                m_fl3 = m_fl3 + 32'(ent.e3[5]);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with hazard-looking inputs present: outputs must stay 0.
        step(1, 0, 0, 5, 1, 5, 1, 0, 1, 0, Z, Z);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
        // Load x5, ID rs2=x5: one bubble on LL1, three on LL3.
        step(0, 0, 0, 5, 1, 5, 1, 0, 0, 0, LU, LU);
        idle(Z, LU);
        idle(Z, LU);
        idle(Z, Z);
        // Load x7, ID rs1=x7.
        step(0, 7, 1, 0, 0, 7, 1, 0, 0, 0, LU, LU);
        idle(Z, LU);
        idle(Z, LU);
        idle(Z, Z);
        // Load to x0, unused-rs match, and non-load match: no stall.
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, Z, Z);
        step(0, 9, 0, 3, 1, 9, 1, 0, 0, 0, Z, Z);
        step(0, 9, 1, 0, 0, 9, 0, 0, 0, 0, Z, Z);
        // Load-use together with redirect: flush wins, no PC stall.
        step(0, 0, 0, 5, 1, 5, 1, 1, 0, 0, BR, BR);
        idle(Z, Z);
        // Redirect during LU_STALL aborts to RUN.
        step(0, 6, 1, 0, 0, 6, 1, 0, 0, 0, LU, LU);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR, BR);
        idle(Z, Z);
        // Four MEM wait cycles then Ack.
        for (int i = 0; i < 4; i++) memw(MW, MW);
        memack(Z, Z);
        idle(Z, Z);
        // MEM wait entered from LU_STALL resumes the remaining two bubbles.
        step(0, 0, 0, 8, 1, 8, 1, 0, 0, 0, LU, LU);
        memw(MW, MW);
        memw(MW, MW);
        memack(Z, Z);
        idle(Z, LU);
        idle(Z, LU);
        idle(Z, Z);
        // Ten wait cycles: error rises on the 8th and stays.
        for (int i = 0; i < 7; i++) memw(MW, MW);
        for (int i = 0; i < 3; i++) memw(MWE, MWE);
        memack(E, E);
        idle(E, E);
        // Reset in the middle of LU_STALL.
        step(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, LUE, LUE);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
        idle(Z, Z);
        // Reset in the middle of MEM_WAIT, then confirm the wait count restarted.
        memw(MW, MW);
        memw(MW, MW);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, Z, Z);
        idle(Z, Z);
        for (int i = 0; i < 7; i++) memw(MW, MW);
        memw(MWE, MWE);
        memack(E, E);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
        idle(Z, Z);
        idle(Z, Z);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", cyc, 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
